execute_muldiv: RTL and testbench
=================================

# execute_muldiv

Iterative, parametrised multiply/divide unit for the RV64IM pipeline execute stage. It replaces single-cycle combinational M-extension arithmetic with a bit-serial datapath that runs over several cycles, and exposes a valid/ready handshake plus a busy stall. Results follow full RISC-V M semantics: all 13 ops including REM/REMU/REMW/REMUW, divide-by-zero and signed overflow. The execute stage steers M-ops here and holds the pipeline while `muldiv_o_busy` is high.

## Interface
- `XLEN`, 64: datapath width, 32 or 64. W-ops are legal only when 64.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `muldiv_i_valid`  in  1  request valid.
- `muldiv_o_ready`  out  1  unit can accept a request this cycle.
- `muldiv_i_op`  in  13  one-hot op, same bit order as execute alu_info[12:0]:
  - 0 remuw, 1 remw, 2 remu, 3 rem, 4 divuw, 5 divw, 6 divu, 7 div
  - 8 mulw, 9 mulhu, 10 mulhsu, 11 mulh, 12 mul
- `muldiv_i_src1`  in  XLEN  rs1 / dividend / multiplicand.
- `muldiv_i_src2`  in  XLEN  rs2 / divisor / multiplier.
- `muldiv_i_flush`  in  1  abort the current op (branch redirect / trap).
- `muldiv_o_valid`  out  1  one-cycle pulse: result is valid.
- `muldiv_o_result`  out  XLEN  registered result.
- `muldiv_o_busy`  out  1  stall request; high in CALC.

## Operation
**States:** IDLE, CALC, DONE.

**Accept:** a request is accepted when `muldiv_i_valid && muldiv_o_ready && !muldiv_i_flush`. On accept, the unit latches the op, the operands and the operand signs.

**Ready:** `muldiv_o_ready = (state != CALC) && !rst`. Back-to-back accept in DONE is allowed.

**Op priority:** a multi-hot op resolves by highest bit index.

**Ops yielding 0 in one cycle:** a zero op, or a W-op when `XLEN==32`, goes straight to DONE with result 0.

**Iteration count N:**
- N = XLEN for full-width ops.
- N = 32 for W-ops. W-ops use src[31:0], sign- or zero-extended per op.
- N does not depend on operand values.
- Multiply: shift-add over operand magnitudes, 2·XLEN product, negated when the product sign requires it.
- Divide: restoring division over magnitudes; quotient and remainder signs are fixed afterwards (remainder takes the dividend's sign).

**Early out (IDLE/DONE → DONE in one cycle, no CALC):**
- Divisor == 0:
  - div family returns all ones.
  - rem family returns the dividend (sign-extended from bit 31 for W).
- Signed overflow (most-negative / −1, at op width):
  - div/divw returns the dividend.
  - rem/remw returns 0.

**Result selection:**
- mul: low XLEN.
- mulh / mulhsu / mulhu: high XLEN, with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- W-ops: 32-bit result sign-extended to 64, including divuw and remuw.

**Transitions:**
- IDLE → CALC on accept, or → DONE on early out.
- CALC → DONE when the iteration counter reaches N−1.
- DONE → CALC or DONE on a new accept, else → IDLE.
- Any state → IDLE on `muldiv_i_flush`; no `muldiv_o_valid` is produced for the flushed op.

**Result register:** `muldiv_o_result` is written on entry to DONE and holds until the next DONE.

## Timing
**Reset values** (the cycle after `rst` is sampled high):
- state = IDLE
- `muldiv_o_valid` = 0
- `muldiv_o_result` = 0
- `muldiv_o_busy` = 0
- `muldiv_o_ready` = 1 once `rst` deasserts

**Reset mid-op:** reset during CALC discards the op with no valid pulse.

**Latency:**
- Normal op accepted at edge T: CALC for cycles T+1 … T+N, `muldiv_o_valid` high for cycle T+N+1.
  - Full 64-bit op: valid at T+65.
  - W-op: valid at T+33.
- Early-out or zero op: valid at T+1.

**Flush precedence:**
- Flush beats accept in the same cycle.
- Flush in DONE suppresses that cycle's accept but does not retract the valid pulse already being presented.

**Busy:** `muldiv_o_busy` = (state == CALC), registered, with no combinational path from inputs.

**Counter:** the iteration counter is $clog2(XLEN) + 1 bits wide and clears on every accept.

## Test plan
- **mul / mulw** (XLEN=64):
  - mul 3 × −5 → 0xFFFF_FFFF_FFFF_FFF1, accepted at T, valid pulse only at T+65, busy high T+1..T+64.
  - mulw 0x7FFF_FFFF × 2 → 0xFFFF_FFFF_FFFF_FFFE at T+33.
- **High products:**
  - mulh 0x8000_0000_0000_0000² → 0x4000_0000_0000_0000.
  - mulhu all-ones × all-ones → 0xFFFF_FFFF_FFFF_FFFE.
  - mulhsu −1 × 2 → 0xFFFF_FFFF_FFFF_FFFF.
- **Early out:**
  - div 7/0 → all ones at T+1.
  - rem 7/0 → 7.
  - div 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000; rem of the same → 0.
  - divw 0x8000_0000 / −1 → 0xFFFF_FFFF_8000_0000; remw of the same → 0.
- **Signedness and W-extension:**
  - divu all-ones / 2 → 0x7FFF_FFFF_FFFF_FFFF.
  - rem −7 / 2 → 0xFFFF_FFFF_FFFF_FFFF.
  - divuw 0xFFFF_FFFE / 1 → 0xFFFF_FFFF_FFFF_FFFE.
  - remuw 5 / 3 → 2.
- **Flush mid-op:** flush at CALC cycle 10 → no valid pulse, ready = 1 the next cycle; a following mul 6 × 7 → 42.
- **Reset and back-to-back:**
  - rst at CALC cycle 20 → outputs at reset values, no valid pulse.
  - New op accepted in the DONE cycle of the previous op → both results correct, no bubble.

Source files
------------

// File: rtl/execute_muldiv.sv
// Iterative RV64IM multiply/divide unit: shift-add multiply and restoring divide over operand
// magnitudes, one bit per cycle, with single-cycle early outs for zero divisors and signed overflow.
module execute_muldiv #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            muldiv_i_valid,
    output logic            muldiv_o_ready,
    input  logic [12:0]     muldiv_i_op,
    input  logic [XLEN-1:0] muldiv_i_src1,
    input  logic [XLEN-1:0] muldiv_i_src2,
    input  logic            muldiv_i_flush,
    output logic            muldiv_o_valid,
    output logic [XLEN-1:0] muldiv_o_result,
    output logic            muldiv_o_busy
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        logic signed [31:0] s;
        s = x;
        return XLEN'(s);
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] x);
        return XLEN'(x);
    endfunction

    state_t              state_q, state_d;
    logic                valid_q, valid_d, busy_q, busy_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [12:0]         op_q, op_d;
    logic                a_neg_q, a_neg_d, b_neg_q, b_neg_d;
    // Multiply: acc = product, opa = multiplicand (shifts left), opb = multiplier (shifts right).
    // Divide: acc[XLEN-1:0] = remainder, opa[XLEN-1:0] = dividend/quotient shifter, opb = divisor.
    logic [2*XLEN-1:0]   acc_q, acc_d, opa_q, opa_d;
    logic [XLEN-1:0]     opb_q, opb_d;

    logic [12:0]         op_sel;
    logic                in_w, in_a_sgn, in_b_sgn, in_mul, in_div, in_rem, in_sdiv;
    logic signed [XLEN-1:0] a_ext, b_ext;
    logic [XLEN-1:0]     mag_a, mag_b, min_val, early_res, fin_res;
    logic                a_neg, b_neg, b_zero, ovf, zero_op, early, accept;
    logic                is_mul_q, is_w_q, div_ok;
    logic [XLEN:0]       rem_sh, diff;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix, rem_fix;
    logic [CW-1:0]       last_cnt;

    assign muldiv_o_ready  = (state_q != CALC) && !rst;
    assign muldiv_o_valid  = valid_q;
    assign muldiv_o_busy   = busy_q;
    assign muldiv_o_result = result_q;
    assign accept          = muldiv_i_valid && muldiv_o_ready && !muldiv_i_flush;

    // Highest set op bit wins.
    always_comb begin
        op_sel = '0;
        for (int i = 0; i < 13; i++) begin
            if (muldiv_i_op[i]) begin
                op_sel    = '0;
                op_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        in_w     = op_sel[0] | op_sel[1] | op_sel[4] | op_sel[5] | op_sel[8];
        in_mul   = |op_sel[12:8];
        in_div   = |op_sel[7:4];
        in_rem   = |op_sel[3:0];
        in_sdiv  = op_sel[7] | op_sel[5] | op_sel[3] | op_sel[1];
        in_a_sgn = op_sel[12] | op_sel[11] | op_sel[10] | op_sel[8] | in_sdiv;
        in_b_sgn = op_sel[12] | op_sel[11] | op_sel[8] | in_sdiv;
        a_ext    = in_w ? (in_a_sgn ? sext32(muldiv_i_src1[31:0]) : zext32(muldiv_i_src1[31:0]))
                        : muldiv_i_src1;
        b_ext    = in_w ? (in_b_sgn ? sext32(muldiv_i_src2[31:0]) : zext32(muldiv_i_src2[31:0]))
                        : muldiv_i_src2;
        a_neg    = in_a_sgn & a_ext[XLEN-1];
        b_neg    = in_b_sgn & b_ext[XLEN-1];
        mag_a    = a_neg ? -a_ext : a_ext;
        mag_b    = b_neg ? -b_ext : b_ext;
        min_val  = in_w ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        b_zero   = (b_ext == '0);
        ovf      = in_sdiv && (a_ext == min_val) && (b_ext == '1);
        zero_op  = (op_sel == '0) || (in_w && (XLEN == 32));
        early    = zero_op || ((in_div || in_rem) && (b_zero || ovf));
        if (zero_op)
            early_res = '0;
        else if (b_zero)
            early_res = in_div ? '1 : (in_w ? sext32(muldiv_i_src1[31:0]) : muldiv_i_src1);
        else
            early_res = in_div ? a_ext : '0;
    end

    always_comb begin
        state_d  = state_q;
        valid_d  = 1'b0;
        busy_d   = 1'b0;
        result_d = result_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;

        is_mul_q = |op_q[12:8];
        is_w_q   = op_q[0] | op_q[1] | op_q[4] | op_q[5] | op_q[8];
        last_cnt = is_w_q ? CW'(31) : CW'(XLEN - 1);
        rem_sh   = {acc_q[XLEN-1:0], opa_q[XLEN-1]};
        diff     = rem_sh - {1'b0, opb_q};
        div_ok   = ~diff[XLEN];
        prod_fix = '0;
        quo_fix  = '0;
        rem_fix  = '0;
        fin_res  = '0;

        if (muldiv_i_flush) begin
            state_d = IDLE;
        end else if (state_q == CALC) begin
            busy_d = 1'b1;
            cnt_d  = cnt_q + CW'(1);
            if (is_mul_q) begin
                acc_d = acc_q + (opb_q[0] ? opa_q : '0);
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
            end else begin
                acc_d = {XLEN'(0), div_ok ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]};
                opa_d = {opa_q[2*XLEN-1:XLEN], opa_q[XLEN-2:0], div_ok};
            end
            // Sign fix-up works on the values produced by this final step.
            prod_fix = (a_neg_q ^ b_neg_q) ? -acc_d : acc_d;
            quo_fix  = (a_neg_q ^ b_neg_q) ? -opa_d[XLEN-1:0] : opa_d[XLEN-1:0];
            rem_fix  = a_neg_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
            if (op_q[12])                       fin_res = prod_fix[XLEN-1:0];
            else if (op_q[11] | op_q[10] | op_q[9]) fin_res = prod_fix[2*XLEN-1:XLEN];
            else if (op_q[8])                   fin_res = sext32(prod_fix[31:0]);
            else if (op_q[7] | op_q[6])         fin_res = quo_fix;
            else if (op_q[5] | op_q[4])         fin_res = sext32(quo_fix[31:0]);
            else if (op_q[3] | op_q[2])         fin_res = rem_fix;
            else if (op_q[1] | op_q[0])         fin_res = sext32(rem_fix[31:0]);
            if (cnt_q == last_cnt) begin
                state_d  = DONE;
                valid_d  = 1'b1;
                busy_d   = 1'b0;
                result_d = fin_res;
            end
        end else if (accept) begin
            if (early) begin
                state_d  = DONE;
                valid_d  = 1'b1;
                result_d = early_res;
            end else begin
                state_d = CALC;
                busy_d  = 1'b1;
                cnt_d   = '0;
                op_d    = op_sel;
                a_neg_d = a_neg;
                b_neg_d = b_neg;
                acc_d   = '0;
                opa_d   = {XLEN'(0), (in_w && !in_mul) ? (mag_a << (XLEN - 32)) : mag_a};
                opb_d   = mag_b;
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        op_q    <= op_d;
        a_neg_q <= a_neg_d;
        b_neg_q <= b_neg_d;
        acc_q   <= acc_d;
        opa_q   <= opa_d;
        opb_q   <= opb_d;
        if (rst) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_execute_muldiv.sv
// Directed testbench for execute_muldiv (XLEN=64): checks results, latency, busy, flush and reset.
module tb_execute_muldiv;
    localparam logic [12:0] OP_REMUW  = 13'd1 << 0;
    localparam logic [12:0] OP_REMW   = 13'd1 << 1;
    localparam logic [12:0] OP_REMU   = 13'd1 << 2;
    localparam logic [12:0] OP_REM    = 13'd1 << 3;
    localparam logic [12:0] OP_DIVUW  = 13'd1 << 4;
    localparam logic [12:0] OP_DIVW   = 13'd1 << 5;
    localparam logic [12:0] OP_DIVU   = 13'd1 << 6;
    localparam logic [12:0] OP_DIV    = 13'd1 << 7;
    localparam logic [12:0] OP_MULW   = 13'd1 << 8;
    localparam logic [12:0] OP_MULHU  = 13'd1 << 9;
    localparam logic [12:0] OP_MULHSU = 13'd1 << 10;
    localparam logic [12:0] OP_MULH   = 13'd1 << 11;
    localparam logic [12:0] OP_MUL    = 13'd1 << 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [12:0] i_op = '0;
    logic [63:0] i_src1 = '0;
    logic [63:0] i_src2 = '0;
    logic        i_flush = 1'b0;
    logic        o_valid;
    logic [63:0] o_result;
    logic        o_busy;

    int tests = 0;
    int fails = 0;

    execute_muldiv #(.XLEN(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .muldiv_i_valid (i_valid),
        .muldiv_o_ready (o_ready),
        .muldiv_i_op    (i_op),
        .muldiv_i_src1  (i_src1),
        .muldiv_i_src2  (i_src2),
        .muldiv_i_flush (i_flush),
        .muldiv_o_valid (o_valid),
        .muldiv_o_result(o_result),
        .muldiv_o_busy  (o_busy)
    );

    always #5 clk = ~clk;

    // Presents one request (caller is at posedge+1), then waits for the valid pulse.
    // lat = cycles from accept edge to the valid cycle, -1 on timeout.
    task automatic do_op(input logic [12:0] op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] res, output int lat, output int busy_n);
        i_valid = 1'b1;
        i_op    = op;
        i_src1  = a;
        i_src2  = b;
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_op    = '0;
        lat     = -1;
        busy_n  = 0;
        res     = '0;
        for (int c = 1; c <= 150; c++) begin
            if (o_busy) busy_n++;
            if (o_valid) begin
                lat = c;
                res = o_result;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_result !== 64'd0) begin
            fails++;
            $display("FAIL reset_outputs: valid=%b busy=%b result=%h, want 0 0 0", o_valid, o_busy, o_result);
        end
        tests++;
        if (o_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready_low: ready=%b, want 0", o_ready);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (o_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready_high: ready=%b, want 1", o_ready);
        end
    endtask

    task automatic test_mul();
        logic [63:0] r;
        int lat, bn;
        do_op(OP_MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, r, lat, bn);
        tests++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFF1 || lat !== 65 || bn !== 64) begin
            fails++;
            $display("FAIL mul_3x-5: got %h lat %0d busy %0d, want fffffffffffffff1 lat 65 busy 64", r, lat, bn);
        end
        @(posedge clk); #1;
        tests++;
        if (o_valid !== 1'b0) begin
            fails++;
            $display("FAIL mul_pulse_width: valid=%b one cycle after pulse, want 0", o_valid);
        end
        do_op(OP_MULW, 64'h7FFF_FFFF, 64'd2, r, lat, bn);
        tests++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFE || lat !== 33 || bn !== 32) begin
            fails++;
            $display("FAIL mulw: got %h lat %0d busy %0d, want fffffffffffffffe lat 33 busy 32", r, lat, bn);
        end
    endtask

    task automatic test_high_products();
        logic [12:0] ops [3];
        logic [63:0] av [3];
        logic [63:0] bv [3];
        logic [63:0] ev [3];
        logic [63:0] r;
        int lat, bn;
        ops[0] = OP_MULH;   av[0] = 64'h8000_0000_0000_0000; bv[0] = 64'h8000_0000_0000_0000; ev[0] = 64'h4000_0000_0000_0000;
        ops[1] = OP_MULHU;  av[1] = '1;                      bv[1] = '1;                      ev[1] = 64'hFFFF_FFFF_FFFF_FFFE;
        ops[2] = OP_MULHSU; av[2] = '1;                      bv[2] = 64'd2;                   ev[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            do_op(ops[i], av[i], bv[i], r, lat, bn);
            tests++;
            if (r !== ev[i] || lat !== 65) begin
                fails++;
                $display("FAIL high_product_%0d: got %h lat %0d, want %h lat 65", i, r, lat, ev[i]);
            end
        end
    endtask

    task automatic test_early_out();
        logic [12:0] ops [7];
        logic [63:0] av [7];
        logic [63:0] bv [7];
        logic [63:0] ev [7];
        logic [63:0] r;
        int lat, bn;
        ops[0] = OP_DIV;  av[0] = 64'd7;                  bv[0] = 64'd0; ev[0] = '1;
        ops[1] = OP_REM;  av[1] = 64'd7;                  bv[1] = 64'd0; ev[1] = 64'd7;
        ops[2] = OP_DIV;  av[2] = 64'h8000_0000_0000_0000; bv[2] = '1;   ev[2] = 64'h8000_0000_0000_0000;
        ops[3] = OP_REM;  av[3] = 64'h8000_0000_0000_0000; bv[3] = '1;   ev[3] = 64'd0;
        ops[4] = OP_DIVW; av[4] = 64'h8000_0000;          bv[4] = '1;    ev[4] = 64'hFFFF_FFFF_8000_0000;
        ops[5] = OP_REMW; av[5] = 64'h8000_0000;          bv[5] = '1;    ev[5] = 64'd0;
        ops[6] = 13'd0;   av[6] = 64'd9;                  bv[6] = 64'd3; ev[6] = 64'd0;
        for (int i = 0; i < 7; i++) begin
            do_op(ops[i], av[i], bv[i], r, lat, bn);
            tests++;
            if (r !== ev[i] || lat !== 1 || bn !== 0) begin
                fails++;
                $display("FAIL early_out_%0d: got %h lat %0d busy %0d, want %h lat 1 busy 0", i, r, lat, bn, ev[i]);
            end
        end
    endtask

    task automatic test_signedness();
        logic [12:0] ops [7];
        logic [63:0] av [7];
        logic [63:0] bv [7];
        logic [63:0] ev [7];
        int el [7];
        logic [63:0] r;
        int lat, bn;
        ops[0] = OP_DIVU;  av[0] = '1;                     bv[0] = 64'd2; ev[0] = 64'h7FFF_FFFF_FFFF_FFFF; el[0] = 65;
        ops[1] = OP_REM;   av[1] = 64'hFFFF_FFFF_FFFF_FFF9; bv[1] = 64'd2; ev[1] = 64'hFFFF_FFFF_FFFF_FFFF; el[1] = 65;
        ops[2] = OP_DIVUW; av[2] = 64'hFFFF_FFFE;          bv[2] = 64'd1; ev[2] = 64'hFFFF_FFFF_FFFF_FFFE; el[2] = 33;
        ops[3] = OP_REMUW; av[3] = 64'd5;                  bv[3] = 64'd3; ev[3] = 64'd2;                  el[3] = 33;
        ops[4] = OP_DIV;   av[4] = 64'hFFFF_FFFF_FFFF_FFEC; bv[4] = 64'd3; ev[4] = 64'hFFFF_FFFF_FFFF_FFFA; el[4] = 65;
        ops[5] = OP_MUL | OP_REMUW; av[5] = 64'd6;         bv[5] = 64'd7; ev[5] = 64'd42;                 el[5] = 65;
        ops[6] = OP_DIVW;  av[6] = 64'h1234_5678_FFFF_FFF1; bv[6] = 64'd4; ev[6] = 64'hFFFF_FFFF_FFFF_FFFD; el[6] = 33;
        for (int i = 0; i < 7; i++) begin
            do_op(ops[i], av[i], bv[i], r, lat, bn);
            tests++;
            if (r !== ev[i] || lat !== el[i]) begin
                fails++;
                $display("FAIL signed_w_%0d: got %h lat %0d, want %h lat %0d", i, r, lat, ev[i], el[i]);
            end
        end
    endtask

    task automatic test_flush();
        logic [63:0] r;
        int lat, bn, seen;
        i_valid = 1'b1; i_op = OP_MUL; i_src1 = 64'd11; i_src2 = 64'd13;
        @(posedge clk); #1;
        i_valid = 1'b0; i_op = '0;
        repeat (9) begin @(posedge clk); #1; end
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        tests++;
        if (o_busy !== 1'b0 || o_ready !== 1'b1 || o_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_calc: busy=%b ready=%b valid=%b, want 0 1 0", o_busy, o_ready, o_valid);
        end
        seen = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (o_valid) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL flush_no_valid: saw %0d valid pulses, want 0", seen);
        end
        do_op(OP_MUL, 64'd6, 64'd7, r, lat, bn);
        tests++;
        if (r !== 64'd42 || lat !== 65) begin
            fails++;
            $display("FAIL mul_after_flush: got %0d lat %0d, want 42 lat 65", r, lat);
        end
        // Flush while the DONE pulse is showing: pulse stays, request is dropped.
        i_valid = 1'b1; i_op = OP_MUL; i_flush = 1'b1;
        tests++;
        if (o_valid !== 1'b1) begin
            fails++;
            $display("FAIL flush_done_pulse: valid=%b, want 1", o_valid);
        end
        @(posedge clk); #1;
        i_valid = 1'b0; i_op = '0; i_flush = 1'b0;
        tests++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_result !== 64'd42) begin
            fails++;
            $display("FAIL flush_done_drop: busy=%b valid=%b result=%0d, want 0 0 42", o_busy, o_valid, o_result);
        end
    endtask

    task automatic test_reset_mid_op();
        int seen;
        i_valid = 1'b1; i_op = OP_MUL; i_src1 = 64'd6; i_src2 = 64'd7;
        @(posedge clk); #1;
        i_valid = 1'b0; i_op = '0;
        repeat (19) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_result !== 64'd0 || o_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_op: valid=%b busy=%b result=%h ready=%b, want 0 0 0 0",
                     o_valid, o_busy, o_result, o_ready);
        end
        rst = 1'b0;
        #1;
        seen = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (o_valid) seen++;
        end
        tests++;
        if (seen !== 0 || o_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_op_quiet: pulses=%0d ready=%b, want 0 1", seen, o_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] r;
        int lat, bn;
        do_op(OP_DIVU, 64'd100, 64'd7, r, lat, bn);
        tests++;
        if (r !== 64'd14 || lat !== 65) begin
            fails++;
            $display("FAIL b2b_divu: got %0d lat %0d, want 14 lat 65", r, lat);
        end
        tests++;
        if (o_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_ready_in_done: ready=%b, want 1", o_ready);
        end
        do_op(OP_REMU, 64'd100, 64'd7, r, lat, bn);
        tests++;
        if (r !== 64'd2 || lat !== 65) begin
            fails++;
            $display("FAIL b2b_remu: got %0d lat %0d, want 2 lat 65", r, lat);
        end
        do_op(OP_DIV, 64'd5, 64'd0, r, lat, bn);
        tests++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF || lat !== 1) begin
            fails++;
            $display("FAIL b2b_early: got %h lat %0d, want ffffffffffffffff lat 1", r, lat);
        end
        do_op(OP_MUL, 64'd6, 64'd7, r, lat, bn);
        tests++;
        if (r !== 64'd42 || lat !== 65) begin
            fails++;
            $display("FAIL b2b_mul: got %0d lat %0d, want 42 lat 65", r, lat);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_high_products();
        test_early_out();
        test_signedness();
        test_flush();
        test_reset_mid_op();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
